// File: rtl/gate_tester.sv
// Stimulus/response checker for the two-input gate library: walks {a,b} through
// all four vectors, samples y_in after a settle time and builds pass/fail maps.
module gate_tester #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_mask,
    output logic [3:0] fail_vec
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    state_t         state;
    logic [1:0]     vec;
    logic [CW-1:0]  cnt;
    logic [5:0]     mismatch_c;

    // Golden truth table, y_in bit order {xor, nor, nand, not(a), or, and}
    function automatic logic [5:0] expected(input logic [1:0] v);
        logic [5:0] e;
        case (v)
            2'b00:   e = 6'b011100;
            2'b01:   e = 6'b101110;
            2'b10:   e = 6'b101010;
            default: e = 6'b000011;
        endcase
        return e;
    endfunction

    assign mismatch_c = y_in ^ expected(vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= '0;
            fail_vec <= '0;
            vec      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_mask <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                        vec      <= '0;
                        {a, b}   <= 2'b00;
                        cnt      <= CW'(SETTLE);
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_mask <= err_mask | mismatch_c;
                    if (|mismatch_c) begin
                        fail_vec[vec] <= 1'b1;
                    end
                    if (vec == 2'd3) begin
                        // Result is registered so it is already valid during DONE
                        pass   <= ((err_mask | mismatch_c) == 6'b0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        {a, b} <= 2'b00;
                        state  <= DONE;
                    end else begin
                        vec    <= vec + 2'd1;
                        {a, b} <= vec + 2'd1;
                        cnt    <= CW'(SETTLE);
                        state  <= WAIT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: a behavioural gate model with stuck-at fault
// injection drives y_in; a second instance covers SETTLE=1.
module tb_gate_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [5:0] s0 = 6'b0;
    logic [5:0] s1 = 6'b0;
    logic [5:0] y_in, y_in1;
    logic       a, b, busy, done, pass;
    logic       a1, b1, busy1, done1, pass1;
    logic [5:0] err_mask, err_mask1;
    logic [3:0] fail_vec, fail_vec1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [5:0] golden(input logic ga, input logic gb);
        return {ga ^ gb, ~(ga | gb), ~(ga & gb), ~ga, ga | gb, ga & gb};
    endfunction

    assign y_in  = (golden(a, b) & ~s0) | s1;
    assign y_in1 = golden(a1, b1);

    gate_tester #(.SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .fail_vec(fail_vec)
    );

    gate_tester #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y_in1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(err_mask1), .fail_vec(fail_vec1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SETTLE=2 run from the current cycle (cycle 0) through the IDLE cycle after DONE
    task automatic run_full(input string tag, input logic exp_pass,
                            input logic [5:0] exp_mask, input logic [3:0] exp_fv);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("%s_ab_c%0d", tag, c), 32'({a, b}), (c <= 12) ? 32'((c - 1) / 3) : 32'd0);
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 12));
            chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == 13));
            if (c < 13) tick();
        end
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_mask"}, 32'(err_mask), 32'(exp_mask));
        chk({tag, "_fv"}, 32'(fail_vec), 32'(exp_fv));
        tick();
        chk({tag, "_done_idle"}, 32'(done), 32'd0);
        chk({tag, "_pass_held"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_mask_held"}, 32'(err_mask), 32'(exp_mask));
    endtask

    initial begin
        int done_cnt;
        int done_at[$];

        // Reset values
        tick();
        chk("rst_ab", 32'({a, b}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_mask", 32'(err_mask), 32'd0);
        chk("rst_fv", 32'(fail_vec), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_hold_busy", 32'(busy), 32'd0);

        run_full("good", 1'b1, 6'b000000, 4'b0000);

        s0 = 6'b100000;
        run_full("xor_s0", 1'b0, 6'b100000, 4'b0110);
        s0 = 6'b000000;

        s1 = 6'b001000;
        run_full("nand_s1", 1'b0, 6'b001000, 4'b1000);
        s1 = 6'b000000;
        run_full("good2", 1'b1, 6'b000000, 4'b0000);

        // Async reset in cycle 7 of a faulty run, after vector 01 already failed
        s0 = 6'b100000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("mid_mask_pre", 32'(err_mask), 32'h20);
        chk("mid_ab_pre", 32'({a, b}), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_ab", 32'({a, b}), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_pass", 32'(pass), 32'd0);
        chk("mid_mask", 32'(err_mask), 32'd0);
        chk("mid_fv", 32'(fail_vec), 32'd0);
        tick();
        rst = 1'b0;
        s0 = 6'b000000;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("mid_no_done", 32'(done_cnt), 32'd0);
        run_full("after_rst", 1'b1, 6'b000000, 4'b0000);

        // start re-pulsed while busy (cycle 3) and in DONE (cycle 13)
        for (int c = 0; c <= 27; c++) begin
            start = (c == 0 || c == 3 || c == 13 || c == 14);
            tick();
            if (done) done_at.push_back(c + 1);
            if (c + 1 == 4) chk("rep_ab_c4", 32'({a, b}), 32'd1);
            if (c + 1 == 14) chk("rep_busy_c14", 32'(busy), 32'd0);
        end
        start = 1'b0;
        chk("rep_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() >= 1) chk("rep_done1", 32'(done_at[0]), 32'd13);
        if (done_at.size() >= 2) chk("rep_done2", 32'(done_at[1]), 32'd27);
        chk("rep_pass", 32'(pass), 32'd1);

        // SETTLE=1 instance with start held high: back-to-back runs
        done_at.delete();
        start1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c + 1 <= 8) begin
                chk($sformatf("s1_ab_c%0d", c + 1), 32'({a1, b1}), 32'(c / 2));
                chk($sformatf("s1_busy_c%0d", c + 1), 32'(busy1), 32'd1);
            end
            if (c + 1 == 9) begin
                chk("s1_pass", 32'(pass1), 32'd1);
                chk("s1_mask", 32'(err_mask1), 32'd0);
                chk("s1_fv", 32'(fail_vec1), 32'd0);
                chk("s1_busy_done", 32'(busy1), 32'd0);
            end
            if (c + 1 == 11) chk("s1_busy_rerun", 32'(busy1), 32'd1);
            if (done1) done_at.push_back(c + 1);
        end
        start1 = 1'b0;
        chk("s1_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() >= 1) chk("s1_done1", 32'(done_at[0]), 32'd9);
        if (done_at.size() >= 2) chk("s1_done2", 32'(done_at[1]), 32'd19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_tester.md
Name: gate_tester

Overview:
- Self-checking sequential stimulus/response block for the two-input gate library (and, or, not, nand, nor, xor).
- Drives the gate inputs a,b through all four input combinations and waits a programmable settle time after each.
- Samples the six gate outputs, compares them against the golden truth table, then reports pass/fail plus per-gate and per-vector failure maps.
- Sits on the opposite side of the gate instances: it is the driver and checker for the library, used on the lab board and in regression.

Parameters:
- SETTLE, 2, number of clock cycles a,b are held before outputs are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a test run; sampled only in IDLE.
- y_in  input  6  gate outputs under test: [0]=and, [1]=or, [2]=not(a), [3]=nand, [4]=nor, [5]=xor.
- a  output  1  gate input a, registered.
- b  output  1  gate input b, registered.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  1 when the last run had zero mismatches; held until the next accepted start.
- err_mask  output  6  sticky OR of mismatching y_in bits over the run.
- fail_vec  output  4  bit {a,b} is set if that vector had any mismatch.

Behaviour:
- Reset (async, any state): state=IDLE; a, b, busy, done and pass = 0; err_mask = 0; fail_vec = 0; vector index = 0; settle counter = 0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - Accepting start clears err_mask, fail_vec and pass, sets vec=0 and {a,b}=2'b00, loads cnt=SETTLE, and goes to WAIT.
  - Without start, IDLE holds.
- WAIT:
  - busy=1; cnt decrements each cycle; the FSM moves to CHECK in the cycle cnt reaches 1.
  - a,b are therefore stable for exactly SETTLE cycles before CHECK.
- CHECK:
  - mismatch = y_in XOR expected(vec); err_mask |= mismatch; fail_vec[vec] set if mismatch != 0.
  - If vec==3: go to DONE.
  - Otherwise: vec+1, {a,b}=vec+1, cnt=SETTLE, back to WAIT.
- Expected y_in[5:0] per {a,b}:
  - 00 -> 6'b011100
  - 01 -> 6'b101110
  - 10 -> 6'b101010
  - 11 -> 6'b000011
- DONE:
  - done=1 for this single cycle; busy=0.
  - pass = (final err_mask==0), registered so it is valid in the DONE cycle.
  - {a,b} returns to 00; next state IDLE.
- Timing, with start sampled in cycle 0:
  - CHECK of vector k occurs in cycle (k+1)(SETTLE+1).
  - done is high in cycle 4(SETTLE+1)+1, i.e. cycle 13 for SETTLE=2.
- Boundary conditions:
  - start while busy or in DONE: ignored, with no effect on outputs.
  - start held high continuously: a new run starts in each IDLE cycle, so runs are back-to-back with one IDLE cycle between them.
  - Reset mid-run: immediate return to the reset values; no done pulse.
  - vec never wraps past 3; fail_vec and err_mask are never cleared except by reset or an accepted start.
  - y_in is sampled only in CHECK; glitches during WAIT are ignored.

Test Plan:
- Correct gate instances, SETTLE=2, start pulsed in cycle 0 -> a,b sequence 00,01,10,11 changing at cycles 1,4,7,10; done=1 only in cycle 13; pass=1, err_mask=000000, fail_vec=0000; busy=1 in cycles 1-12.
- y_in[5] (xor) stuck at 0 -> pass=0, err_mask=6'b100000, fail_vec=4'b0110.
- y_in[3] (nand) stuck at 1 -> pass=0, err_mask=6'b001000, fail_vec=4'b1000; a second run with correct gates -> pass=1 and the maps are cleared.
- rst asserted asynchronously in cycle 7 of a run -> a=b=busy=done=pass=0 and maps=0 immediately; no done pulse; a later start runs a full test normally.
- start re-pulsed in cycles 3 and 13 (the DONE cycle) -> both ignored; done pulse count=1; a start in cycle 14 begins a new run, with done in cycle 27.
- SETTLE=1 -> CHECK in cycles 2,4,6,8; done in cycle 9; results identical to the first scenario.
